// File: rtl/regfile_pkg.sv
// Shared constants and small helpers for the register-file write-back arbiter.
package regfile_pkg;

  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 4;

  // Round-robin successor of idx among n requesters.
  function automatic int wrap_inc(input int idx, input int n);
    int nxt;
    nxt = idx + 32'sd1;
    if (nxt >= n) begin
      nxt = 32'sd0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin grant selection: first valid requester at or above rr_ptr, wrapping.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;
  logic          w_found;

  // Scan NREQ positions starting at rr_ptr; sum stays below 2*NREQ so one subtraction wraps it.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ)) begin
        w_sum = w_sum - (IW+1)'(NREQ);
      end else begin
        w_sum = w_sum;
      end
      w_idx = w_sum[IW-1:0];
      if (!w_found && valid[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter feeding a single register-file write port.
// Optional read bypass ports are added when REGFILE_WB_BYPASS_EN is defined.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int AW   = AW_DEF,
  parameter  int DW   = DW_DEF,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               stall,
  output logic               writeen,
  output logic [AW-1:0]      addrw,
  output logic [DW-1:0]      writeint,
  output logic [GW-1:0]      grant_id
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [AW-1:0]      rd_addr1,
  input  logic [AW-1:0]      rd_addr2,
  input  logic [DW-1:0]      rd_data1_in,
  input  logic [DW-1:0]      rd_data2_in,
  output logic [DW-1:0]      rd_data1,
  output logic [DW-1:0]      rd_data2
`endif
);

  logic [GW-1:0]   r_rr_ptr;
  logic            r_writeen;
  logic [AW-1:0]   r_addrw;
  logic [DW-1:0]   r_writeint;
  logic [GW-1:0]   r_grant_id;

  logic [NREQ-1:0] w_arb_grant;
  logic [NREQ-1:0] w_grant;
  logic            w_xfer;
  logic [GW-1:0]   w_gidx;
  logic [GW-1:0]   w_next_ptr;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .valid  (req_valid),
    .rr_ptr (r_rr_ptr),
    .grant  (w_arb_grant)
  );

  // Reset and stall both suppress grants.
  always_comb begin
    w_grant = '0;
    if (rst || stall) begin
      w_grant = '0;
    end else begin
      w_grant = w_arb_grant;
    end
  end

  assign req_ready = w_grant;
  assign w_xfer    = |w_grant;

  // One-hot AND-OR mux of the granted requester's index, address and data.
  always_comb begin
    w_gidx     = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_gidx     = w_gidx     | ({GW{w_grant[i]}} & GW'(i));
      w_sel_addr = w_sel_addr | ({AW{w_grant[i]}} & req_addr[i*AW +: AW]);
      w_sel_data = w_sel_data | ({DW{w_grant[i]}} & req_data[i*DW +: DW]);
    end
    w_next_ptr = GW'(wrap_inc(int'(w_gidx), NREQ));
  end

  // Register the transfer; address-0 writes advance the pointer but never reach the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_writeen  <= 1'b0;
      r_addrw    <= '0;
      r_writeint <= '0;
      r_grant_id <= '0;
    end else if (w_xfer) begin
      r_rr_ptr  <= w_next_ptr;
      r_writeen <= (w_sel_addr != '0);
      if (w_sel_addr != '0) begin
        r_addrw    <= w_sel_addr;
        r_writeint <= w_sel_data;
        r_grant_id <= w_gidx;
      end
    end else begin
      r_writeen <= 1'b0;
    end
  end

  assign writeen  = r_writeen;
  assign addrw    = r_addrw;
  assign writeint = r_writeint;
  assign grant_id = r_grant_id;

`ifdef REGFILE_WB_BYPASS_EN
  // Forward the in-flight write to readers; register 0 always reads zero.
  always_comb begin
    rd_data1 = rd_data1_in;
    if (r_writeen && (r_addrw == rd_addr1)) begin
      rd_data1 = r_writeint;
    end else if (rd_addr1 == '0) begin
      rd_data1 = '0;
    end else begin
      rd_data1 = rd_data1_in;
    end
    rd_data2 = rd_data2_in;
    if (r_writeen && (r_addrw == rd_addr2)) begin
      rd_data2 = r_writeint;
    end else if (rd_addr2 == '0) begin
      rd_data2 = '0;
    end else begin
      rd_data2 = rd_data2_in;
    end
  end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2: number of write requesters, legal 2..4.
REQ-002 SHALL have parameter AW, default 5: register address width.
REQ-003 SHALL have parameter DW, default 32: register data width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  NREQ  requester i has a write pending.
REQ-007 SHALL have port req_ready  output  NREQ  requester i granted this cycle.
REQ-008 SHALL have port req_addr  input  NREQ*AW  requester i address at [i*AW +: AW].
REQ-009 SHALL have port req_data  input  NREQ*DW  requester i data at [i*DW +: DW].
REQ-010 SHALL have port stall  input  1  register write port blocked; no grants.
REQ-011 SHALL have port writeen  output  1  register file write enable.
REQ-012 SHALL have port addrw  output  AW  register file write address.
REQ-013 SHALL have port writeint  output  DW  register file write data.
REQ-014 SHALL have port grant_id  output  $clog2(NREQ)  index of requester whose write is on writeen/addrw/writeint.

Function
REQ-015 SHALL treat a transfer as req_valid[i] & req_ready[i] in the same cycle.
REQ-016 SHALL drive req_ready combinationally: at most one bit high, zero when stall=1 or no valid.
REQ-017 SHALL grant the first valid requester found scanning upward from rr_ptr, wrapping NREQ-1 -> 0.
REQ-018 SHALL update rr_ptr to (granted index + 1) mod NREQ on a transfer; hold rr_ptr otherwise.
REQ-019 SHALL register each transfer: at the following posedge writeen=1, addrw/writeint/grant_id = granted requester's values; latency 1 cycle, throughput 1 write/cycle.
REQ-020 SHALL hold writeen=1 for exactly one cycle per transfer; writeen=0 in any cycle after a cycle without transfer.
REQ-021 SHALL accept a transfer with address 0 (req_ready=1, rr_ptr advances) but keep writeen=0 for it.
REQ-022 SHALL, for two requesters targeting the same address in one cycle, grant only one; the other lands in a later cycle, so last-granted wins.
REQ-023 SHALL hold addrw/writeint/grant_id unchanged in cycles where writeen=0.
REQ-024 SHALL ignore stall for an already-registered write (writeen still asserts next cycle).

Reset
REQ-025 SHALL, while rst=1, force writeen=0, addrw=0, writeint=0, grant_id=0, rr_ptr=0, req_ready=0.
REQ-026 SHALL discard a registered write pending when rst asserts mid-operation; first grant after release goes to requester 0 if valid.

Configuration
REQ-027 SHALL, with REGFILE_WB_BYPASS_EN defined, add ports rd_addr1/rd_addr2 (in, AW), rd_data1_in/rd_data2_in (in, DW), rd_data1/rd_data2 (out, DW): rd_dataN = writeint when writeen=1 and addrw==rd_addrN, 0 when rd_addrN==0, else rd_dataN_in (combinational).
REQ-028 SHALL, without REGFILE_WB_BYPASS_EN, omit those ports and logic entirely.

Structure
REQ-029 SHALL take default AW/DW constants from shared package regfile_pkg.
REQ-030 SHALL place grant selection in sub-module rr_arbiter (inputs valid, rr_ptr; output one-hot grant).

Verification
REQ-031 SHALL test: req_valid=2'b11, rr_ptr=0, addrs 3/4, data 0xA/0xB -> grant 0 then 1; writeen two cycles, addrw 3 then 4.
REQ-032 SHALL test: req0 valid with addr 0, data 0xFF -> req_ready[0]=1, writeen stays 0, rr_ptr becomes 1.
REQ-033 SHALL test: stall=1 with both valid for 3 cycles -> req_ready=0, writeen=0; stall drop -> grant resumes at rr_ptr.
REQ-034 SHALL test: both requesters addr 7, data 0x1/0x2, rr_ptr=0 -> writes land in order 0x1, 0x2.
REQ-035 SHALL test: rst pulse one cycle after a grant -> writeen never asserts, all outputs 0, next grant is requester 0.
REQ-036 SHALL test (REGFILE_WB_BYPASS_EN): writeen=1, addrw=5, writeint=0x1234, rd_addr1=5, rd_data1_in=0 -> rd_data1=0x1234; rd_addr2=0 -> rd_data2=0.
